// File: rtl/mips_muldiv.sv
// MIPS HI/LO multiply/divide unit.
// Handles 32x32 signed/unsigned multiply (shift-add) and divide (restoring,
// on magnitudes). Each operation takes 32 iterations. HI/LO only change when
// a result lands or on MTHI/MTLO.
module mips_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [63:0] r_work;
    logic [31:0] r_opnd;
    logic [31:0] r_aRaw;
    logic        r_negLo;
    logic        r_negHi;
    logic        r_divZero;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed;
    logic        w_aNeg;
    logic        w_bNeg;
    logic [31:0] w_aMag;
    logic [31:0] w_bMag;
    logic [32:0] w_mulSum;
    logic [63:0] w_mulNext;
    logic [63:0] w_mulResult;
    logic [32:0] w_divShift;
    logic        w_divGe;
    logic [31:0] w_divRem;
    logic [31:0] w_divQuo;
    logic [31:0] w_divLo;
    logic [31:0] w_divHi;
    logic        w_lastStep;

    // Operand conditioning: signed ops work on magnitudes and fix the sign at the end.
    always_comb begin
        w_signed = ~op_i[0];
        w_aNeg   = w_signed & a_i[31];
        w_bNeg   = w_signed & b_i[31];
        w_aMag   = w_aNeg ? (32'd0 - a_i) : a_i;
        w_bMag   = w_bNeg ? (32'd0 - b_i) : b_i;
    end

    // One datapath step: r_work is {partial product, multiplier} for MUL and
    // {partial remainder, dividend/quotient} for DIV.
    always_comb begin
        w_mulSum    = {1'b0, r_work[63:32]} + (r_work[0] ? {1'b0, r_opnd} : 33'd0);
        w_mulNext   = {w_mulSum, r_work[31:1]};
        w_mulResult = r_negLo ? (64'd0 - w_mulNext) : w_mulNext;

        w_divShift  = {r_work[63:32], r_work[31]};
        w_divGe     = (w_divShift >= {1'b0, r_opnd});
        w_divRem    = w_divGe ? (w_divShift[31:0] - r_opnd) : w_divShift[31:0];
        w_divQuo    = {r_work[30:0], w_divGe};
        w_divLo     = r_divZero ? 32'hFFFF_FFFF : (r_negLo ? (32'd0 - w_divQuo) : w_divQuo);
        w_divHi     = r_divZero ? r_aRaw : (r_negHi ? (32'd0 - w_divRem) : w_divRem);

        w_lastStep  = (r_count == 5'd31);
    end

    // Control FSM with registered busy/done and the architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= 5'd0;
            r_work    <= 64'd0;
            r_opnd    <= 32'd0;
            r_aRaw    <= 32'd0;
            r_negLo   <= 1'b0;
            r_negHi   <= 1'b0;
            r_divZero <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (start_i) begin
                        r_state   <= op_i[1] ? DIV : MUL;
                        r_busy    <= 1'b1;
                        r_count   <= 5'd0;
                        r_work    <= {32'd0, w_aMag};
                        r_opnd    <= w_bMag;
                        r_aRaw    <= a_i;
                        r_negLo   <= w_aNeg ^ w_bNeg;
                        r_negHi   <= w_aNeg;
                        r_divZero <= (b_i == 32'd0);
                    end else begin
                        if (mthi_i) r_hi <= a_i;
                        if (mtlo_i) r_lo <= a_i;
                    end
                end
                MUL: begin
                    r_work  <= w_mulNext;
                    r_count <= r_count + 5'd1;
                    if (w_lastStep) begin
                        r_hi    <= w_mulResult[63:32];
                        r_lo    <= w_mulResult[31:0];
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DIV: begin
                    r_work  <= {w_divRem, w_divQuo};
                    r_count <= r_count + 5'd1;
                    if (w_lastStep) begin
                        r_hi    <= w_divHi;
                        r_lo    <= w_divLo;
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mips_muldiv;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        mthi_i;
    logic        mtlo_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int compared;
    int mismatched;
    logic [31:0] modelHi;
    logic [31:0] modelLo;

    mips_muldiv dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .mthi_i  (mthi_i),
        .mtlo_i  (mtlo_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every comparison and report any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result {HI, LO} computed with plain 64-bit arithmetic.
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'd0;
        case (op)
            2'b00: res = sa * sb;
            2'b01: res = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {a % b, a / b};
                end
            end
        endcase
        return res;
    endfunction

    // Run one operation end to end; optionally start straight from the DONE cycle
    // and optionally raise MTHI/MTLO alongside start (they must be dropped).
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit backToBack, input bit withMove);
        int cycles;
        int busyCycles;
        logic [63:0] exp;
        if (!backToBack) begin
            @(negedge clk);
            checkOutput("doneOnce", {63'd0, done_o}, 64'd0);
        end
        exp = refModel(op, a, b);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        mthi_i  = withMove;
        mtlo_i  = withMove;
        @(negedge clk);
        start_i = 1'b0;
        mthi_i  = 1'b0;
        mtlo_i  = 1'b0;
        a_i     = $urandom;
        b_i     = $urandom;
        cycles = 0;
        busyCycles = 0;
        while (!done_o && cycles < 40) begin
            if (busy_o) busyCycles++;
            if (cycles == 10) begin
                start_i = 1'b1;
                mthi_i  = 1'b1;
                mtlo_i  = 1'b1;
                op_i    = 2'($urandom);
            end else if (cycles == 11) begin
                start_i = 1'b0;
                mthi_i  = 1'b0;
                mtlo_i  = 1'b0;
            end else if (cycles == 12) begin
                checkOutput("holdHiLo", {hi_o, lo_o}, {modelHi, modelLo});
            end
            @(negedge clk);
            cycles++;
        end
        checkOutput("busyLen", 64'(busyCycles), 64'd32);
        checkOutput("donePulse", {62'd0, done_o, busy_o}, 64'd2);
        checkOutput("result", {hi_o, lo_o}, exp);
        modelHi = exp[63:32];
        modelLo = exp[31:0];
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        compared   = 0;
        mismatched = 0;
        modelHi    = 32'd0;
        modelLo    = 32'd0;
        rst     = 1'b1;
        start_i = 1'b0;
        op_i    = 2'b00;
        a_i     = 32'h1111_1111;
        b_i     = 32'd0;
        mthi_i  = 1'b1;
        mtlo_i  = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("resetState", {hi_o, lo_o}, 64'd0);
        checkOutput("resetCtrl", {62'd0, busy_o, done_o}, 64'd0);
        rst    = 1'b0;
        mthi_i = 1'b0;
        mtlo_i = 1'b0;

        // Directed corner cases.
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 1'b0);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        applyStimulus(2'b11, 32'h0000_0064, 32'h0000_0000, 1'b0, 1'b0);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        applyStimulus(2'b10, 32'hFFFF_FF00, 32'h0000_0000, 1'b0, 1'b1);

        // MTHI then MTLO while idle.
        @(negedge clk);
        mthi_i = 1'b1;
        a_i    = 32'h0000_1234;
        @(negedge clk);
        mthi_i = 1'b0;
        mtlo_i = 1'b1;
        a_i    = 32'h0000_5678;
        checkOutput("mthi", {32'd0, hi_o}, 64'h1234);
        @(negedge clk);
        mtlo_i = 1'b0;
        checkOutput("mtlo", {hi_o, lo_o}, {32'h1234, 32'h5678});
        // Both moves together.
        mthi_i = 1'b1;
        mtlo_i = 1'b1;
        a_i    = 32'hCAFE_F00D;
        @(negedge clk);
        mthi_i = 1'b0;
        mtlo_i = 1'b0;
        checkOutput("mtBoth", {hi_o, lo_o}, {32'hCAFE_F00D, 32'hCAFE_F00D});
        modelHi = 32'hCAFE_F00D;
        modelLo = 32'hCAFE_F00D;

        // Busy-period check, then restart and reset mid-operation.
        applyStimulus(2'b01, 32'd2, 32'd3, 1'b0, 1'b0);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = 2'b01;
        a_i     = 32'd2;
        b_i     = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b1;
        mthi_i  = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        mthi_i  = 1'b0;
        checkOutput("midReset", {hi_o, lo_o}, 64'd0);
        checkOutput("midResetCtrl", {62'd0, busy_o, done_o}, 64'd0);
        modelHi = 32'd0;
        modelLo = 32'd0;
        begin
            int sawDone;
            sawDone = 0;
            repeat (40) begin
                @(negedge clk);
                if (done_o) sawDone++;
            end
            checkOutput("noDoneAfterReset", 64'(sawDone), 64'd0);
        end

        // Randomized operations, some forced to edge operands.
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = $urandom_range(1, 15);
                default: ;
            endcase
            applyStimulus(rop, ra, rb, bit'(i % 3 == 1), 1'b0);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
